// File: rtl/wb_regfile_unit_if.sv
// M/W pipeline bundle with valid/ready handshake into the writeback register-file unit.
interface wb_regfile_unit_if #(
  parameter int unsigned IdxW  = 4,
  parameter int unsigned LaneW = 32,
  parameter int unsigned Lanes = 4
);
  logic                   wb_valid;
  logic                   wb_ready;
  logic                   regw_W;
  logic                   regmem_W;
  logic                   vec_W;
  logic [IdxW-1:0]        regScr_W;
  logic [LaneW-1:0]       ALUrslt_W;
  logic [LaneW-1:0]       memdata_W;
  logic [Lanes*LaneW-1:0] regVrslt_W;

  modport master (
    output wb_valid, regw_W, regmem_W, vec_W, regScr_W, ALUrslt_W, memdata_W, regVrslt_W,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, regw_W, regmem_W, vec_W, regScr_W, ALUrslt_W, memdata_W, regVrslt_W,
    output wb_ready
  );
endinterface

// File: rtl/wb_regfile_unit.sv
// Writeback unit: commits the M/W bundle into the scalar and vector register files it owns,
// one vector lane per cycle, and serves decode read ports with scalar write-through bypass.
module wb_regfile_unit #(
  parameter int unsigned NReg  = 16,
  parameter int unsigned Lanes = 4,
  parameter int unsigned LaneW = 32,
  parameter int unsigned IdxW  = $clog2(NReg)
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_regfile_unit_if.slave       wb,
  input  logic [IdxW-1:0]        sra1,
  input  logic [IdxW-1:0]        sra2,
  output logic [LaneW-1:0]       srd1,
  output logic [LaneW-1:0]       srd2,
  input  logic [IdxW-1:0]        vra,
  output logic [Lanes*LaneW-1:0] vrd,
  output logic                   busy,
  output logic [IdxW-1:0]        busy_dst
);

  localparam int unsigned LaneIdxW = (Lanes > 1) ? $clog2(Lanes) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StVwr  = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic [LaneIdxW-1:0]           lane_q, lane_d;
  logic [IdxW-1:0]               dst_q;
  logic [Lanes-1:0][LaneW-1:0]   vbuf_q;
  logic [LaneW-1:0]              sreg_q [NReg];
  logic [Lanes-1:0][LaneW-1:0]   vreg_q [NReg];

  logic             accept;
  logic             s_we;
  logic             v_start;
  logic             v_we;
  logic             last_lane;
  logic [LaneW-1:0] s_wdata;

  assign accept    = wb.wb_valid & (state_q == StIdle);
  assign s_wdata   = wb.regmem_W ? wb.memdata_W : wb.ALUrslt_W;
  // Writes to scalar register 0 are dropped so it always reads zero.
  assign s_we      = accept & wb.regw_W & ~wb.vec_W & (wb.regScr_W != '0);
  assign v_start   = accept & wb.regw_W & wb.vec_W;
  assign v_we      = (state_q == StVwr);
  assign last_lane = (lane_q == LaneIdxW'(Lanes - 1));

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      StIdle: begin
        if (v_start) begin
          state_d = StVwr;
          lane_d  = '0;
        end
      end
      StVwr: begin
        if (last_lane) begin
          state_d = StIdle;
          lane_d  = '0;
        end else begin
          lane_d = lane_q + LaneIdxW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        lane_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lane_q  <= '0;
      dst_q   <= '0;
      vbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (v_start) begin
        dst_q  <= wb.regScr_W;
        vbuf_q <= wb.regVrslt_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NReg); i++) begin
        sreg_q[i] <= '0;
        vreg_q[i] <= '0;
      end
    end else begin
      if (s_we) begin
        sreg_q[wb.regScr_W] <= s_wdata;
      end
      if (v_we) begin
        vreg_q[dst_q][lane_q] <= vbuf_q[lane_q];
      end
    end
  end

  always_comb begin
    srd1 = sreg_q[sra1];
    if (sra1 == '0) begin
      srd1 = '0;
    end else if (s_we && (sra1 == wb.regScr_W)) begin
      srd1 = s_wdata;
    end
  end

  always_comb begin
    srd2 = sreg_q[sra2];
    if (sra2 == '0) begin
      srd2 = '0;
    end else if (s_we && (sra2 == wb.regScr_W)) begin
      srd2 = s_wdata;
    end
  end

  // No vector bypass: readers see partially committed lanes and must stall on busy_dst.
  assign vrd         = vreg_q[vra];
  assign wb.wb_ready = (state_q == StIdle);
  assign busy        = (state_q == StVwr);
  assign busy_dst    = dst_q;

endmodule
